// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch unit bus bundle.
// Groups the two handshakes around the fetch stage plus the branch controls
// that come back from decode/execute for the held instruction.
//   Instruction memory : IMemReq, IMemAddr -> ; <- IMemRdata, IMemAck
//   Decode             : Instr, InstrValid, CurrentPC -> ; <- InstrReady
//   Branch resolution  : <- BusImm, Branch, Uncondbranch, ALUZero
//   Statistics         : FetchCount ->
// Modport master is the fetch unit; modport slave is the memory/decode side.
interface instruction_fetch_unit_if #(
  parameter int CNT_W = 32
);
  logic             IMemReq;
  logic [63:0]      IMemAddr;
  logic [31:0]      IMemRdata;
  logic             IMemAck;
  logic [31:0]      Instr;
  logic             InstrValid;
  logic             InstrReady;
  logic [63:0]      CurrentPC;
  logic [63:0]      BusImm;
  logic             Branch;
  logic             Uncondbranch;
  logic             ALUZero;
  logic [CNT_W-1:0] FetchCount;

  modport master (
    output IMemReq, IMemAddr, Instr, InstrValid, CurrentPC, FetchCount,
    input  IMemRdata, IMemAck, InstrReady, BusImm, Branch, Uncondbranch, ALUZero
  );

  modport slave (
    input  IMemReq, IMemAddr, Instr, InstrValid, CurrentPC, FetchCount,
    output IMemRdata, IMemAck, InstrReady, BusImm, Branch, Uncondbranch, ALUZero
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit.
// Owns the PC, fetches one 32-bit instruction at a time from instruction
// memory (req/ack), holds it for decode (valid/ready) and computes the next
// PC from the branch controls sampled in the accept cycle.
// Ports:
//   CLK      clock, all state changes on the rising edge
//   Reset_n  synchronous active-low reset
//   bus      instruction_fetch_unit_if.master (memory, decode, branch, count)
// Parameters:
//   RESET_PC first fetch address after reset
//   CNT_W    width of FetchCount; must match the interface instance
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic CLK,
  input  logic Reset_n,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [63:0]      pc;
  logic             imem_req;
  logic [31:0]      instr;
  logic             instr_valid;
  logic [63:0]      current_pc;
  logic [CNT_W-1:0] fetch_count;
  logic [63:0]      next_pc;

  // Branch target: immediate is a word offset, so scale by 4 before the
  // two's-complement add; carry out of bit 63 is dropped (PC wraps).
  function automatic logic [63:0] calc_next_pc(
    input logic [63:0] cur,
    input logic [63:0] imm,
    input logic        branch,
    input logic        uncond,
    input logic        zero
  );
    logic signed [63:0] imm_s;
    logic signed [63:0] offset;
    logic               taken;
    imm_s  = signed'(imm);
    offset = imm_s <<< 2;
    taken  = uncond | (branch & zero);
    return taken ? (cur + 64'(offset)) : (cur + 64'd4);
  endfunction

  assign next_pc = calc_next_pc(current_pc, bus.BusImm, bus.Branch,
                                bus.Uncondbranch, bus.ALUZero);

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      current_pc  <= RESET_PC;
      fetch_count <= '0;
    end else begin
      case (state)
        S_REQ: begin
          // imem_req is low only in the first cycle after reset; an ack seen
          // then belongs to a request abandoned by reset and is dropped.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (bus.IMemAck) begin
            instr       <= bus.IMemRdata;
            current_pc  <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Any IMemAck here is a protocol violation and is ignored.
          if (bus.InstrReady) begin
            fetch_count <= fetch_count + 1'b1;
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_REQ;
          end
        end
        default: begin
          state    <= S_REQ;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IMemReq    = imem_req;
  assign bus.IMemAddr   = pc;
  assign bus.Instr      = instr;
  assign bus.InstrValid = instr_valid;
  assign bus.CurrentPC  = current_pc;
  assign bus.FetchCount = fetch_count;

endmodule
